// File: rtl/inst_mem_loader_if.sv
// ---------------------------------------------------------------------------
// inst_mem_loader_if
// Bundles the program-load port and the fetch port of the loadable
// instruction memory.
//   master : host/fetch side (drives load_*, fetch_req, fetch_addr, stall)
//   slave  : the memory itself (drives load_done, load_count, ready,
//            inst_out, inst_valid, addr_fault)
// Parameters A (address width) and W (instruction width) must match the
// memory instance the interface is connected to.
// ---------------------------------------------------------------------------
interface inst_mem_loader_if #(
  parameter int A = 8,
  parameter int W = 9
);
  // load port
  logic         load_start;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_last;
  logic         load_done;
  logic [A:0]   load_count;
  // fetch port
  logic         ready;
  logic         fetch_req;
  logic [A-1:0] fetch_addr;
  logic         stall;
  logic [W-1:0] inst_out;
  logic         inst_valid;
  logic         addr_fault;

  modport master (
    output load_start, load_valid, load_data, load_last,
    output fetch_req, fetch_addr, stall,
    input  load_done, load_count, ready, inst_out, inst_valid, addr_fault
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    input  fetch_req, fetch_addr, stall,
    output load_done, load_count, ready, inst_out, inst_valid, addr_fault
  );
endinterface

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
// Loadable instruction memory. The host streams a program image in through
// the load port (EMPTY -> LOAD -> RUN); the fetch stage then reads it with a
// registered, 1-cycle-latency request/valid handshake that holds its outputs
// while stall is high. Fetches at or beyond the loaded image length return
// NOP_VAL with addr_fault set.
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : inst_mem_loader_if.slave
//            load_start/load_valid/load_data/load_last -> load_done/load_count
//            fetch_req/fetch_addr/stall -> ready/inst_out/inst_valid/addr_fault
// ---------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int           A       = 8,
  parameter int           W       = 9,
  parameter int           DEPTH   = 256,
  parameter logic [W-1:0] NOP_VAL = 9'b111_000000
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_mem_loader_if.slave  bus
);

  localparam int         CNT_W    = A + 1;
  localparam logic [A:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [A:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_RUN
  } state_t;

  state_t       state_q, state_d;
  logic [A:0]   load_count_q;
  logic         load_done_q;
  logic [W-1:0] inst_out_q;
  logic         inst_valid_q;
  logic         addr_fault_q;

  logic         wr_en;
  logic         finish;
  logic         fetch_accept;
  logic         rd_fault;

  logic [W-1:0] mem [DEPTH];

  // -------------------------------------------------------------------------
  // Next-state and control decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    wr_en        = 1'b0;
    finish       = 1'b0;
    fetch_accept = 1'b0;

    unique case (state_q)
      S_EMPTY: begin
        if (bus.load_start) state_d = S_LOAD;
      end

      S_LOAD: begin
        // load_start restarts the image; a word offered in the same cycle
        // is dropped.
        if (bus.load_start) begin
          state_d = S_LOAD;
        end else if (bus.load_valid) begin
          wr_en = 1'b1;
          // The last storage word finishes the load even without load_last,
          // so the write pointer can never run past DEPTH-1.
          if (bus.load_last || (load_count_q == LAST_CNT)) begin
            finish  = 1'b1;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        // load_start wins over a simultaneous fetch, which is dropped.
        if (bus.load_start) begin
          state_d = S_LOAD;
        end else if (bus.fetch_req && !bus.stall) begin
          fetch_accept = 1'b1;
        end
      end

      default: state_d = S_EMPTY;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Load bookkeeping. load_count doubles as the write pointer: during LOAD
  // it always equals the index of the next word to be written.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count_q <= '0;
      load_done_q  <= 1'b0;
    end else begin
      load_done_q <= finish;
      if (bus.load_start) begin
        load_count_q <= '0;
      end else if (wr_en && (load_count_q != CNT_MAX)) begin
        load_count_q <= load_count_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage array
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset; a reset only clears load_count, which is
  // enough to make every stale word unreachable until the next load.
  always_ff @(posedge clk) begin
    if (wr_en) mem[load_count_q[A-1:0]] <= bus.load_data;
  end

  // -------------------------------------------------------------------------
  // Fetch pipeline (1-cycle latency, stall holds the output stage)
  // -------------------------------------------------------------------------
  assign rd_fault = ({1'b0, bus.fetch_addr} >= load_count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_out_q   <= NOP_VAL;
      inst_valid_q <= 1'b0;
      addr_fault_q <= 1'b0;
    end else if ((state_q != S_RUN) || bus.load_start) begin
      // Outside RUN, or when leaving it, nothing is valid; inst_out holds.
      inst_valid_q <= 1'b0;
      addr_fault_q <= 1'b0;
    end else if (!bus.stall) begin
      if (fetch_accept) begin
        inst_valid_q <= 1'b1;
        addr_fault_q <= rd_fault;
        // Out-of-image addresses never index the array result.
        inst_out_q   <= rd_fault ? NOP_VAL : mem[bus.fetch_addr];
      end else begin
        inst_valid_q <= 1'b0;
        addr_fault_q <= 1'b0;
      end
    end
  end

  assign bus.ready      = (state_q == S_RUN);
  assign bus.load_done  = load_done_q;
  assign bus.load_count = load_count_q;
  assign bus.inst_out   = inst_out_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.addr_fault = addr_fault_q;

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Parametrised, loadable instruction memory; successor to the fixed 8-entry opcode ROM.
- Host loads the program image through a streaming load port.
- The fetch stage then reads instructions with a registered, stall-aware request/valid handshake.
- Fetches beyond the loaded image return a NOP and flag a fault.

Parameters:
A, 8, instruction address width.
W, 9, instruction width (3-bit opcode + 6-bit operand field).
DEPTH, 256, number of storage words; must satisfy 1 <= DEPTH <= 2**A.
NOP_VAL, 9'b111_000000, word returned for unloaded or out-of-range addresses.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Reset_n  input  1  asynchronous active-low reset.
LoadStart  input  1  begin (or restart) a program load.
LoadValid  input  1  LoadData is valid this cycle.
LoadData  input  W  instruction word to store.
LoadLast  input  1  qualifies LoadValid; marks the final word of the image.
LoadDone  output  1  one-cycle pulse when the load completes.
LoadCount  output  A+1  number of words in the current image.
Ready  output  1  memory is in RUN and accepts fetches.
FetchReq  input  1  fetch request.
FetchAddr  input  A  fetch address.
Stall  input  1  downstream stall; hold the fetch outputs.
InstOut  output  W  fetched instruction.
InstValid  output  1  InstOut is valid.
AddrFault  output  1  accompanies InstValid; the fetch address was >= LoadCount.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state=EMPTY; write pointer=0.
  - LoadCount=0, LoadDone=0, Ready=0, InstValid=0, AddrFault=0, InstOut=NOP_VAL.
  - Storage array is not cleared.
- States: EMPTY, LOAD, RUN. Ready=1 only in RUN (registered state decode).
- EMPTY:
  - LoadStart=1 -> LOAD; pointer=0; LoadCount=0.
  - All other inputs are ignored.
- LOAD:
  - Each cycle with LoadValid=1: mem[ptr]<=LoadData, ptr++, LoadCount++.
  - LoadValid=1 with LoadLast=1, or a write at ptr==DEPTH-1, stores the word then -> RUN. LoadDone=1 for exactly that following cycle.
  - Writes beyond DEPTH are impossible; the auto-finish at DEPTH words takes effect regardless of LoadLast.
  - LoadStart=1 in LOAD restarts: ptr=0, LoadCount=0; any LoadValid in the same cycle is discarded.
  - FetchReq is ignored; InstValid=0.
- RUN:
  - Fetch is accepted when FetchReq=1 and Stall=0. The next cycle delivers:
    - InstValid=1.
    - InstOut=mem[FetchAddr] and AddrFault=0 if FetchAddr<LoadCount.
    - Otherwise InstOut=NOP_VAL and AddrFault=1.
  - Latency is 1 cycle; back-to-back fetches give one result per cycle.
  - Stall=1: InstOut, InstValid and AddrFault hold their values; FetchReq is not accepted, and the requester keeps it asserted.
  - FetchReq=0 with Stall=0: InstValid<=0, AddrFault<=0, InstOut holds.
  - LoadStart=1 -> LOAD, ptr=0, LoadCount=0, InstValid<=0. LoadStart has priority over a simultaneous FetchReq, which is dropped.
- LoadValid outside LOAD is ignored; LoadLast without LoadValid is ignored.
- LoadCount saturates at DEPTH (A+1 bits, so DEPTH=2**A is representable).
- Reset asserted mid-load or mid-fetch returns to EMPTY. Partially written contents remain, but LoadCount=0 makes every later fetch fault until a reload.

Test Plan:
1. Reset, then LoadStart and 4 words 0x0A1, 0x0B2, 0x0C3, 0x1D4 with LoadLast on the 4th -> LoadDone pulses 1 cycle, LoadCount=4, Ready=1. Fetches to addresses 0..3 return the words in order, 1-cycle latency, AddrFault=0.
2. Same image; fetch address 7 -> InstOut=0x1C0 (NOP_VAL), InstValid=1, AddrFault=1.
3. Fetch addr 2 with Stall=1 asserted for 3 cycles after issue -> InstOut=0x0C3 and InstValid=1 held for all 3 cycles. A new FetchReq to addr 3 is only accepted after Stall drops.
4. DEPTH=4, A=2; stream 6 words without LoadLast -> RUN after the 4th word, LoadDone once, LoadCount=4, words 5 and 6 ignored.
5. In RUN, LoadStart and FetchReq in the same cycle -> LOAD entered, InstValid=0, Ready=0 next cycle. Reload of 2 words gives LoadCount=2; fetch addr 3 then faults.
6. Reset_n pulsed low after 2 of 4 load words -> all outputs at reset values immediately (asynchronous), state=EMPTY. Fetch attempts are ignored (Ready=0) until a new load completes.
